// File: rtl/demux2_buf_pkg.sv
// Shared definitions for the 1-to-2 buffered demultiplexer slice:
// select encoding, default sizing and the occupancy-counter width helper.
package demux2_buf_pkg;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_e;

    localparam int unsigned DEF_N     = 32;
    localparam int unsigned DEF_DEPTH = 2;

    // Count needs one extra bit beyond the pointer so full and empty differ.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/demux2_buf_fifo_sync.sv
// Small synchronous FIFO: registered storage, wrapping pointers, separate count.
// Head is always the word at rd_ptr, so an empty FIFO shows a stale but defined word.
module fifo_sync
    import demux2_buf_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [N-1:0]                  wdata,
    input  logic                          pop,
    output logic [N-1:0]                  head,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = count_width(DEPTH);

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            mem    <= '{default: '0};
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux2_buf.sv
// 1-to-2 demultiplexer: each input word is steered by s_sel into the A or B FIFO,
// so a stalled consumer only back-pressures words bound for its own output.
module demux2_buf
    import demux2_buf_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    input  logic                          s_sel,
    input  logic [N-1:0]                  s_data,
    output logic                          s_ready,
    output logic                          a_valid,
    output logic [N-1:0]                  a_data,
    input  logic                          a_ready,
    output logic [count_width(DEPTH)-1:0] a_count,
    output logic                          b_valid,
    output logic [N-1:0]                  b_data,
    input  logic                          b_ready,
    output logic [count_width(DEPTH)-1:0] b_count
);

    logic a_full;
    logic b_full;
    logic a_empty;
    logic b_empty;
    logic push_a;
    logic push_b;
    logic pop_a;
    logic pop_b;

    // Ready looks only at the destination's registered fullness: no pass-through on pop.
    assign s_ready = (s_sel == SEL_B) ? ~b_full : ~a_full;
    assign push_a  = s_valid & s_ready & (s_sel == SEL_A);
    assign push_b  = s_valid & s_ready & (s_sel == SEL_B);

    assign a_valid = ~a_empty;
    assign b_valid = ~b_empty;
    assign pop_a   = a_valid & a_ready;
    assign pop_b   = b_valid & b_ready;

    fifo_sync #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .push  (push_a),
        .wdata (s_data),
        .pop   (pop_a),
        .head  (a_data),
        .full  (a_full),
        .empty (a_empty),
        .count (a_count)
    );

    fifo_sync #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .push  (push_b),
        .wdata (s_data),
        .pop   (pop_b),
        .head  (b_data),
        .full  (b_full),
        .empty (b_empty),
        .count (b_count)
    );

endmodule

// File: tb/tb_demux2_buf.sv
// Bench for demux2_buf: directed scenarios plus randomized traffic, each output
// compared against a pair of queue-based reference FIFOs.
module tb_demux2_buf;

    localparam int unsigned N     = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_sel;
    logic [N-1:0]  s_data;
    logic          s_ready;
    logic          a_valid;
    logic [N-1:0]  a_data;
    logic          a_ready;
    logic [CW-1:0] a_count;
    logic          b_valid;
    logic [N-1:0]  b_data;
    logic          b_ready;
    logic [CW-1:0] b_count;

    logic [N-1:0] qa[$];
    logic [N-1:0] qb[$];
    logic [N-1:0] dut_a[$];
    logic [N-1:0] dut_b[$];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    demux2_buf #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_sel   (s_sel),
        .s_data  (s_data),
        .s_ready (s_ready),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .a_count (a_count),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .b_count (b_count)
    );

    // Advance one clock; the reference FIFOs apply the same cycle's accept/pop rules.
    task automatic tick();
        bit acc;
        bit pa;
        bit pb;
        logic [N-1:0] w;
        acc = !rst && s_valid && ((s_sel ? qb.size() : qa.size()) < DEPTH);
        pa  = !rst && a_ready && (qa.size() != 0);
        pb  = !rst && b_ready && (qb.size() != 0);
        if (!rst && a_valid && a_ready) dut_a.push_back(a_data);
        if (!rst && b_valid && b_ready) dut_b.push_back(b_data);
        @(posedge clk);
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            if (pa) w = qa.pop_front();
            if (pb) w = qb.pop_front();
            if (acc) begin
                if (s_sel) qb.push_back(s_data);
                else       qa.push_back(s_data);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_sel = 1'b0; s_data = '0;
        a_ready = 1'b0; b_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid got %0b want 0", a_valid); end
        n_checks++; if (b_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_valid got %0b want 0", b_valid); end
        n_checks++; if (a_count !== '0) begin n_fail++; $display("FAIL reset_a_count got %0d want 0", a_count); end
        n_checks++; if (b_count !== '0) begin n_fail++; $display("FAIL reset_b_count got %0d want 0", b_count); end
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got %0b want 1", s_ready); end
        n_checks++; if (a_data !== '0) begin n_fail++; $display("FAIL reset_a_data got %h want 0", a_data); end
        n_checks++; if (b_data !== '0) begin n_fail++; $display("FAIL reset_b_data got %h want 0", b_data); end
    endtask

    task automatic test_steering();
        a_ready = 1'b1; b_ready = 1'b1;
        s_valid = 1'b1; s_sel = 1'b0; s_data = 32'h1111_1111;
        #1;
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL steer_ready_a got %0b want 1", s_ready); end
        tick();
        s_sel = 1'b1; s_data = 32'h2222_2222;
        #1;
        n_checks++; if (a_valid !== 1'b1 || a_data !== 32'h1111_1111) begin n_fail++; $display("FAIL steer_a got v=%0b d=%h want v=1 d=11111111", a_valid, a_data); end
        n_checks++; if (b_valid !== 1'b0) begin n_fail++; $display("FAIL steer_b_idle got %0b want 0", b_valid); end
        tick();
        s_valid = 1'b0;
        #1;
        n_checks++; if (b_valid !== 1'b1 || b_data !== 32'h2222_2222) begin n_fail++; $display("FAIL steer_b got v=%0b d=%h want v=1 d=22222222", b_valid, b_data); end
        n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL steer_a_idle got %0b want 0", a_valid); end
        tick();
        n_checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin n_fail++; $display("FAIL steer_drain got a=%0b b=%0b want 0 0", a_valid, b_valid); end
    endtask

    task automatic test_full();
        a_ready = 1'b0; b_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_sel = 1'b1; s_data = N'(32'hB0 + i);
            #1;
            n_checks++; if (s_ready !== (qb.size() < DEPTH)) begin n_fail++; $display("FAIL full_fill_ready[%0d] got %0b want %0b", i, s_ready, qb.size() < DEPTH); end
            tick();
        end
        n_checks++; if (b_count !== CW'(2)) begin n_fail++; $display("FAIL full_b_count got %0d want 2", b_count); end
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL full_s_ready got %0b want 0", s_ready); end
        s_sel = 1'b0; s_data = 32'hA5;
        #1;
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL full_switch_ready got %0b want 1", s_ready); end
        tick();
        s_valid = 1'b0;
        #1;
        n_checks++; if (a_valid !== 1'b1 || a_data !== 32'hA5 || a_count !== CW'(1)) begin n_fail++; $display("FAIL full_a_land got v=%0b d=%h c=%0d want 1 a5 1", a_valid, a_data, a_count); end
        n_checks++; if (b_data !== 32'hB0 || b_count !== CW'(2)) begin n_fail++; $display("FAIL full_b_hold got d=%h c=%0d want b0 2", b_data, b_count); end
        // Full with a pop in the same cycle still refuses the push.
        b_ready = 1'b1; s_valid = 1'b1; s_sel = 1'b1; s_data = 32'hBB;
        #1;
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_passthru got %0b want 0", s_ready); end
        tick();
        s_valid = 1'b0;
        #1;
        n_checks++; if (b_count !== CW'(1) || b_data !== 32'hB1) begin n_fail++; $display("FAIL full_after_pop got c=%0d d=%h want 1 b1", b_count, b_data); end
        a_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (a_count !== '0 || b_count !== '0) begin n_fail++; $display("FAIL full_drain got a=%0d b=%0d want 0 0", a_count, b_count); end
    endtask

    task automatic test_push_pop();
        dut_a.delete();
        a_ready = 1'b0; b_ready = 1'b0;
        s_valid = 1'b1; s_sel = 1'b0; s_data = 32'hC0;
        tick();
        n_checks++; if (a_count !== CW'(1) || a_data !== 32'hC0) begin n_fail++; $display("FAIL pp_setup got c=%0d d=%h want 1 c0", a_count, a_data); end
        a_ready = 1'b1; s_data = 32'hC1;
        tick();
        s_valid = 1'b0;
        #1;
        n_checks++; if (a_count !== CW'(1) || a_data !== 32'hC1) begin n_fail++; $display("FAIL pp_same_cycle got c=%0d d=%h want 1 c1", a_count, a_data); end
        tick();
        n_checks++; if (a_count !== '0 || a_valid !== 1'b0) begin n_fail++; $display("FAIL pp_empty got c=%0d v=%0b want 0 0", a_count, a_valid); end
        n_checks++;
        if (dut_a.size() != 2 || dut_a[0] !== 32'hC0 || dut_a[1] !== 32'hC1) begin
            n_fail++; $display("FAIL pp_order got %0d words want c0,c1", dut_a.size());
        end
    endtask

    task automatic test_wrap();
        int unsigned sent = 0;
        int unsigned cyc  = 0;
        dut_a.delete();
        b_ready = 1'b0;
        while ((sent < 10 || qa.size() != 0) && cyc < 200) begin
            s_valid = (sent < 10); s_sel = 1'b0; s_data = N'(sent); a_ready = cyc[0];
            #1;
            n_checks++; if (a_count !== CW'(qa.size())) begin n_fail++; $display("FAIL wrap_count c%0d got %0d want %0d", cyc, a_count, qa.size()); end
            if (s_valid && qa.size() < DEPTH) sent++;
            tick();
            cyc++;
        end
        s_valid = 1'b0;
        n_checks++; if (cyc >= 200) begin n_fail++; $display("FAIL wrap_timeout got %0d cycles want <200", cyc); end
        n_checks++; if (dut_a.size() != 10) begin n_fail++; $display("FAIL wrap_len got %0d want 10", dut_a.size()); end
        for (int k = 0; k < 10 && k < dut_a.size(); k++) begin
            n_checks++; if (dut_a[k] !== N'(k)) begin n_fail++; $display("FAIL wrap_word[%0d] got %h want %h", k, dut_a[k], k); end
        end
    endtask

    task automatic test_reset_midop();
        int unsigned na;
        int unsigned nb;
        a_ready = 1'b0; b_ready = 1'b0; s_valid = 1'b1;
        s_sel = 1'b0; s_data = 32'hD0; tick();
        s_sel = 1'b0; s_data = 32'hD1; tick();
        s_sel = 1'b1; s_data = 32'hD2; tick();
        n_checks++; if (a_count !== CW'(2) || b_count !== CW'(1)) begin n_fail++; $display("FAIL mid_setup got a=%0d b=%0d want 2 1", a_count, b_count); end
        na = dut_a.size(); nb = dut_b.size();
        rst = 1'b1; a_ready = 1'b1; b_ready = 1'b1; s_data = 32'hD3;
        tick();
        rst = 1'b0; s_valid = 1'b0;
        #1;
        n_checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got a=%0b b=%0b want 0 0", a_valid, b_valid); end
        n_checks++; if (a_count !== '0 || b_count !== '0) begin n_fail++; $display("FAIL mid_count got a=%0d b=%0d want 0 0", a_count, b_count); end
        s_valid = 1'b1; s_sel = 1'b1; s_data = 32'h77; b_ready = 1'b0;
        tick();
        s_valid = 1'b0;
        #1;
        n_checks++; if (b_count !== CW'(1) || b_data !== 32'h77 || a_count !== '0) begin n_fail++; $display("FAIL mid_fresh got b=%0d d=%h a=%0d want 1 77 0", b_count, b_data, a_count); end
        n_checks++; if (dut_a.size() != na || dut_b.size() != nb) begin n_fail++; $display("FAIL mid_no_fire got a=%0d b=%0d want %0d %0d", dut_a.size(), dut_b.size(), na, nb); end
        b_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst     = ($urandom_range(0, 63) == 0);
            s_valid = $urandom_range(0, 1) == 1;
            s_sel   = $urandom_range(0, 1) == 1;
            s_data  = $urandom;
            a_ready = $urandom_range(0, 2) != 0;
            b_ready = $urandom_range(0, 3) == 0;
            #1;
            n_checks++; if (s_ready !== ((s_sel ? qb.size() : qa.size()) < DEPTH)) begin n_fail++; $display("FAIL rnd_ready c%0d got %0b", c, s_ready); end
            n_checks++; if (a_count !== CW'(qa.size()) || a_valid !== (qa.size() != 0)) begin n_fail++; $display("FAIL rnd_a_state c%0d got c=%0d v=%0b want c=%0d", c, a_count, a_valid, qa.size()); end
            n_checks++; if (b_count !== CW'(qb.size()) || b_valid !== (qb.size() != 0)) begin n_fail++; $display("FAIL rnd_b_state c%0d got c=%0d v=%0b want c=%0d", c, b_count, b_valid, qb.size()); end
            if (qa.size() != 0) begin
                n_checks++; if (a_data !== qa[0]) begin n_fail++; $display("FAIL rnd_a_data c%0d got %h want %h", c, a_data, qa[0]); end
            end
            if (qb.size() != 0) begin
                n_checks++; if (b_data !== qb[0]) begin n_fail++; $display("FAIL rnd_b_data c%0d got %h want %h", c, b_data, qb[0]); end
            end
            tick();
        end
        rst = 1'b0; s_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_sel = 1'b0; s_data = '0;
        a_ready = 1'b0; b_ready = 1'b0;
        #2;
        test_reset();
        test_steering();
        test_full();
        test_push_pop();
        test_wrap();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
